// File: rtl/mfda_sense_pkg.sv
// Shared definitions for the microfluidic sensing blocks: default widths and
// the outlet front detector state encoding.
package mfda_sense_pkg;

    localparam int DEF_SAMPLE_W  = 12;
    localparam int DEF_TIME_W    = 24;
    localparam int DEF_CONFIRM_N = 4;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_REPORT  = 2'd3
    } front_state_e;

endpackage

// File: rtl/outlet_front_detector_if.sv
// Report channel of the outlet front detector. A transfer happens on a cycle with
// rpt_valid && rpt_ready; the payload is held unchanged from rpt_valid rising until then.
// rpt_peak exists only when OUTLET_FRONT_DETECTOR_PEAK_EN is defined.
interface outlet_front_detector_if
    import mfda_sense_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int TIME_W   = DEF_TIME_W
);
    logic              rpt_valid;
    logic              rpt_ready;
    logic [TIME_W-1:0] rpt_time;
    logic              rpt_timeout;
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
    logic [SAMPLE_W-1:0] rpt_peak;

    modport master (output rpt_valid, output rpt_time, output rpt_timeout, output rpt_peak, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_time, input rpt_timeout, input rpt_peak, output rpt_ready);
`else
    modport master (output rpt_valid, output rpt_time, output rpt_timeout, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_time, input rpt_timeout, output rpt_ready);
`endif
endinterface

// File: rtl/mfda_sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over en.
module mfda_sat_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/outlet_front_detector.sv
// Measures fluid-front transit time from start to CONFIRM_N consecutive above-threshold
// outlet samples, with optional timeout. Define OUTLET_FRONT_DETECTOR_PEAK_EN to add rpt_peak.
module outlet_front_detector
    import mfda_sense_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int TIME_W    = DEF_TIME_W,
    parameter int CONFIRM_N = DEF_CONFIRM_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [TIME_W-1:0]   timeout,
    output logic                busy,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [TIME_W-1:0]   rpt_time,
    output logic                rpt_timeout
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
    ,
    output logic [SAMPLE_W-1:0] rpt_peak
`endif
);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_N);

    front_state_e        state_q, state_d;
    logic [SAMPLE_W-1:0] thr_q, thr_d;
    logic [TIME_W-1:0]   tmo_q, tmo_d;
    logic [TIME_W-1:0]   arrival_q, arrival_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TIME_W-1:0]   rpt_time_q, rpt_time_d;
    logic                rpt_timeout_q, rpt_timeout_d;

    logic [TIME_W-1:0]   timer;
    logic                timer_clr, timer_en;
    logic                above, tmo_hit, take_start, confirm_done;
    logic [CNT_W-1:0]    count_inc;

    mfda_sat_counter #(.W(TIME_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    assign above      = sample_valid && (sample >= thr_q);
    assign tmo_hit    = (tmo_q != '0) && (timer == tmo_q);
    assign take_start = (state_q == ST_IDLE) && start;
    assign count_inc  = count_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        thr_d         = thr_q;
        tmo_d         = tmo_q;
        arrival_d     = arrival_q;
        count_d       = count_q;
        rpt_time_d    = rpt_time_q;
        rpt_timeout_d = rpt_timeout_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;
        confirm_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d     = threshold;
                    tmo_d     = timeout;
                    arrival_d = '0;
                    count_d   = '0;
                    timer_clr = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT, ST_CONFIRM: begin
                timer_en = 1'b1;
                if (above) begin
                    if (state_q == ST_WAIT) begin
                        arrival_d    = timer;
                        count_d      = CNT_W'(1);
                        state_d      = ST_CONFIRM;
                        confirm_done = (CONFIRM_LAST == CNT_W'(1));
                    end else begin
                        count_d      = count_inc;
                        confirm_done = (count_inc == CONFIRM_LAST);
                    end
                end else if (sample_valid && (state_q == ST_CONFIRM)) begin
                    count_d = '0;
                    state_d = ST_WAIT;
                end
                // A completed confirmation outranks a coincident timeout.
                if (confirm_done) begin
                    state_d       = ST_REPORT;
                    rpt_time_d    = (state_q == ST_WAIT) ? timer : arrival_q;
                    rpt_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d       = ST_REPORT;
                    rpt_time_d    = tmo_q;
                    rpt_timeout_d = 1'b1;
                end
            end
            ST_REPORT: begin
                if (rpt_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            thr_q         <= '0;
            tmo_q         <= '0;
            arrival_q     <= '0;
            count_q       <= '0;
            rpt_time_q    <= '0;
            rpt_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            thr_q         <= thr_d;
            tmo_q         <= tmo_d;
            arrival_q     <= arrival_d;
            count_q       <= count_d;
            rpt_time_q    <= rpt_time_d;
            rpt_timeout_q <= rpt_timeout_d;
        end
    end

`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
    logic [SAMPLE_W-1:0] peak_q, peak_d;

    // Peak only tracks while measuring, so it is frozen for the whole report.
    always_comb begin
        peak_d = peak_q;
        if (take_start) begin
            peak_d = '0;
        end else if (((state_q == ST_WAIT) || (state_q == ST_CONFIRM)) && sample_valid && (sample > peak_q)) begin
            peak_d = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign rpt_peak = peak_q;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign rpt_valid   = (state_q == ST_REPORT);
    assign rpt_time    = rpt_time_q;
    assign rpt_timeout = rpt_timeout_q;
endmodule

// File: tb/tb_outlet_front_detector.sv
// Bench for outlet_front_detector: directed scenarios plus randomized measurements
// checked against a sample-sequence reference model.
module tb_outlet_front_detector;
    localparam int SW  = 12;
    localparam int TW  = 24;
    localparam int CN  = 4;
    localparam int MAX_T = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic [SW-1:0] threshold = '0;
    logic [TW-1:0] timeout = '0;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic          v_arr [0:MAX_T-1];
    logic [SW-1:0] s_arr [0:MAX_T-1];

    outlet_front_detector_if #(.SAMPLE_W(SW), .TIME_W(TW)) rpt_if ();

    outlet_front_detector #(.SAMPLE_W(SW), .TIME_W(TW), .CONFIRM_N(CN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .threshold    (threshold),
        .timeout      (timeout),
        .busy         (busy),
        .rpt_valid    (rpt_if.rpt_valid),
        .rpt_ready    (rpt_if.rpt_ready),
        .rpt_time     (rpt_if.rpt_time),
        .rpt_timeout  (rpt_if.rpt_timeout)
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
        ,
        .rpt_peak     (rpt_if.rpt_peak)
`endif
    );

    always #5 clk = ~clk;

    // Outcome of a measurement: find the first cycle whose last CN valid samples
    // are all at/above threshold, unless the timeout cycle comes first.
    function automatic void model(input logic [SW-1:0] thr, input logic [TW-1:0] tmo, input int len,
                                  output int dec_t, output logic [TW-1:0] e_time,
                                  output logic e_to, output logic [SW-1:0] e_peak);
        int vidx[$];
        bit all_hi;
        dec_t = -1; e_time = '0; e_to = 1'b0; e_peak = '0;
        for (int t = 0; t < len; t++) begin
            if (v_arr[t]) begin
                vidx.push_back(t);
                if (s_arr[t] > e_peak) e_peak = s_arr[t];
                if (vidx.size() >= CN) begin
                    all_hi = 1'b1;
                    for (int k = 0; k < CN; k++)
                        if (s_arr[vidx[vidx.size() - 1 - k]] < thr) all_hi = 1'b0;
                    if (all_hi) begin
                        dec_t = t; e_time = TW'(vidx[vidx.size() - CN]); e_to = 1'b0;
                        return;
                    end
                end
            end
            if ((tmo != '0) && (t == int'(tmo))) begin
                dec_t = t; e_time = tmo; e_to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic fill(input int from, input int to, input logic v, input logic [SW-1:0] s);
        for (int t = from; t <= to; t++) begin
            v_arr[t] = v; s_arr[t] = s;
        end
    endtask

    task automatic run_measurement(input logic [SW-1:0] thr, input logic [TW-1:0] tmo, input int len,
                                   input int rdy_dly, input bit start_in_rpt,
                                   output logic [TW-1:0] o_time, output logic o_to,
                                   output logic [SW-1:0] o_peak);
        int            dec_t;
        logic [TW-1:0] e_time;
        logic          e_to;
        logic [SW-1:0] e_peak;
        model(thr, tmo, len, dec_t, e_time, e_to, e_peak);
        o_time = '0; o_to = 1'b0; o_peak = '0;
        if (dec_t < 0) begin
            n_err++;
            $display("FAIL model_outcome: sequence of %0d samples has no decision, need one", len);
            return;
        end
        start = 1'b1; threshold = thr; timeout = tmo;
        @(posedge clk); #1;
        start = 1'b0;
        threshold = SW'($urandom); timeout = TW'($urandom);
        for (int t = 0; t <= dec_t; t++) begin
            sample_valid = v_arr[t]; sample = s_arr[t];
            @(posedge clk); #1;
            n_vec++;
            if (rpt_if.rpt_valid !== (t == dec_t)) begin
                n_err++;
                $display("FAIL rpt_valid_timing: t=%0d got %b need %b (decision at %0d)", t, rpt_if.rpt_valid, (t == dec_t), dec_t);
            end
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_measuring: t=%0d got %b need 1", t, busy);
            end
        end
        o_time = rpt_if.rpt_time; o_to = rpt_if.rpt_timeout;
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
        o_peak = rpt_if.rpt_peak;
`endif
        sample_valid = 1'b1; sample = '1;
        for (int c = 0; c <= rdy_dly; c++) begin
            n_vec++;
            if (rpt_if.rpt_valid !== 1'b1 || rpt_if.rpt_time !== e_time || rpt_if.rpt_timeout !== e_to) begin
                n_err++;
                $display("FAIL report_payload: cyc=%0d valid=%b time=%0d to=%b need valid=1 time=%0d to=%b",
                         c, rpt_if.rpt_valid, rpt_if.rpt_time, rpt_if.rpt_timeout, e_time, e_to);
            end
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
            n_vec++;
            if (rpt_if.rpt_peak !== e_peak) begin
                n_err++;
                $display("FAIL report_peak: cyc=%0d got %h need %h", c, rpt_if.rpt_peak, e_peak);
            end
`endif
            if (c == rdy_dly) rpt_if.rpt_ready = 1'b1;
            if (c == 1 && start_in_rpt) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        rpt_if.rpt_ready = 1'b0; sample_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || rpt_if.rpt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_handshake: busy=%b valid=%b need 0 0", busy, rpt_if.rpt_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rpt_if.rpt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || rpt_if.rpt_valid !== 1'b0 || rpt_if.rpt_time !== '0 || rpt_if.rpt_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b valid=%b time=%0d to=%b need all 0",
                     busy, rpt_if.rpt_valid, rpt_if.rpt_time, rpt_if.rpt_timeout);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_during_reset: busy=%b need 0", busy);
        end
    endtask

    task automatic test_detect();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        fill(0, 9, 1'b1, 12'h100); fill(10, 13, 1'b1, 12'h900);
        run_measurement(12'h800, '0, 14, 0, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd10 || oto !== 1'b0) begin
            n_err++; $display("FAIL detect_basic: time=%0d to=%b need 10 0", ot, oto);
        end
        fill(0, 9, 1'b1, 12'h100); fill(10, 12, 1'b1, 12'h900); fill(13, 13, 1'b1, 12'h7FF);
        fill(14, 19, 1'b1, 12'h100); fill(20, 23, 1'b1, 12'h900);
        run_measurement(12'h800, '0, 24, 1, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd20 || oto !== 1'b0) begin
            n_err++; $display("FAIL detect_restart: time=%0d to=%b need 20 0", ot, oto);
        end
        // Samples exactly at threshold, with idle cycles inside the run.
        fill(0, 4, 1'b1, 12'h7FF); fill(5, 10, 1'b1, 12'h800);
        fill(6, 6, 1'b0, 12'h000); fill(9, 9, 1'b0, 12'h000);
        run_measurement(12'h800, '0, 11, 0, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd5 || oto !== 1'b0) begin
            n_err++; $display("FAIL detect_equal_gaps: time=%0d to=%b need 5 0", ot, oto);
        end
    endtask

    task automatic test_timeout();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        fill(0, 59, 1'b1, 12'h100);
        run_measurement(12'h800, 24'd50, 60, 0, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd50 || oto !== 1'b1) begin
            n_err++; $display("FAIL timeout_basic: time=%0d to=%b need 50 1", ot, oto);
        end
        fill(0, 9, 1'b1, 12'h100); fill(10, 13, 1'b1, 12'h900);
        run_measurement(12'h800, 24'd13, 14, 0, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd10 || oto !== 1'b0) begin
            n_err++; $display("FAIL timeout_tie: time=%0d to=%b need 10 0", ot, oto);
        end
    endtask

    task automatic test_report_hold();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        fill(0, 9, 1'b1, 12'h100); fill(10, 13, 1'b1, 12'h900);
        run_measurement(12'h800, '0, 14, 5, 1'b1, ot, oto, op);
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL start_in_report_ignored: busy=%b need 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        start = 1'b1; threshold = 12'h800; timeout = '0;
        @(posedge clk); #1;
        start = 1'b0; sample_valid = 1'b1; sample = 12'h900;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; sample_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || rpt_if.rpt_valid !== 1'b0 || rpt_if.rpt_time !== '0 || rpt_if.rpt_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_confirm: busy=%b valid=%b time=%0d to=%b need all 0",
                     busy, rpt_if.rpt_valid, rpt_if.rpt_time, rpt_if.rpt_timeout);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        fill(0, 2, 1'b1, 12'h100); fill(3, 6, 1'b1, 12'h900);
        run_measurement(12'h800, '0, 7, 0, 1'b0, ot, oto, op);
        n_vec++;
        if (ot !== 24'd3 || oto !== 1'b0) begin
            n_err++; $display("FAIL fresh_after_reset: time=%0d to=%b need 3 0", ot, oto);
        end
    endtask

`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
    task automatic test_peak();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        fill(0, 0, 1'b1, 12'h900); fill(1, 1, 1'b1, 12'hA00);
        fill(2, 2, 1'b1, 12'h950); fill(3, 3, 1'b1, 12'h980);
        run_measurement(12'h800, '0, 4, 2, 1'b0, ot, oto, op);
        n_vec++;
        if (op !== 12'hA00 || ot !== 24'd0) begin
            n_err++; $display("FAIL peak_value: peak=%h time=%0d need a00 0", op, ot);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        for (int i = 0; i < 2; i++) begin
            fill(0, 1 + i, 1'b1, 12'h010); fill(2 + i, 5 + i, 1'b1, 12'hFFF);
            run_measurement(12'h800, '0, 6 + i, 0, 1'b0, ot, oto, op);
            n_vec++;
            if (ot !== TW'(2 + i)) begin
                n_err++; $display("FAIL back_to_back: run=%0d time=%0d need %0d", i, ot, 2 + i);
            end
        end
    endtask

    task automatic test_random();
        logic [TW-1:0] ot; logic oto; logic [SW-1:0] op;
        logic [SW-1:0] thr;
        logic [TW-1:0] tmo;
        for (int it = 0; it < 30; it++) begin
            thr = SW'($urandom_range(1, 4095));
            tmo = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(5, 85));
            for (int t = 0; t < 90; t++) begin
                v_arr[t] = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 9) < 6) s_arr[t] = SW'($urandom_range(int'(thr), 4095));
                else s_arr[t] = SW'($urandom_range(0, int'(thr) - 1));
            end
            fill(86, 89, 1'b1, 12'hFFF);
            run_measurement(thr, tmo, 90, $urandom_range(0, 3), bit'($urandom_range(0, 1)), ot, oto, op);
        end
    endtask

    initial begin
        rpt_if.rpt_ready = 1'b0;
        test_reset();
        test_detect();
        test_timeout();
        test_report_hold();
        test_reset_mid();
`ifdef OUTLET_FRONT_DETECTOR_PEAK_EN
        test_peak();
`endif
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/outlet_front_detector.md
OUTLET_FRONT_DETECTOR -- requirements
Module: outlet_front_detector

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12: outlet concentration sample width (unsigned).
REQ-002 SHALL have parameter TIME_W, default 24: transit timer width in clock cycles.
REQ-003 SHALL have parameter CONFIRM_N, default 4: consecutive above-threshold samples that confirm a front (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse: solution injection began at the chip inlet.
REQ-007 SHALL have port sample_valid  input  1  outlet sensor sample present this cycle.
REQ-008 SHALL have port sample  input  SAMPLE_W  outlet concentration reading.
REQ-009 SHALL have port threshold  input  SAMPLE_W  front-detection level, captured at start.
REQ-010 SHALL have port timeout  input  TIME_W  maximum wait in cycles, captured at start; 0 disables timeout.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port rpt_valid  output  1  report available.
REQ-013 SHALL have port rpt_ready  input  1  consumer accepts report.
REQ-014 SHALL have port rpt_time  output  TIME_W  fluid-front arrival time in cycles after start.
REQ-015 SHALL have port rpt_timeout  output  1  report was produced by timeout, not by detection.

Function
REQ-016 SHALL implement states IDLE, WAIT, CONFIRM, REPORT.
REQ-017 In IDLE, start SHALL capture threshold and timeout, clear timer and confirm count, and move to WAIT; start outside IDLE SHALL be ignored.
REQ-018 Timer SHALL read 0 in the first WAIT cycle, increment by 1 each cycle in WAIT/CONFIRM, and saturate at all-ones.
REQ-019 Above-threshold SHALL mean sample_valid and unsigned sample >= captured threshold; cycles without sample_valid SHALL leave the state and count unchanged.
REQ-020 In WAIT, an above-threshold sample SHALL latch arrival = current timer, set count to 1, and enter CONFIRM, or enter REPORT directly when CONFIRM_N = 1.
REQ-021 In CONFIRM, an above-threshold sample SHALL increment count, and on reaching CONFIRM_N SHALL enter REPORT with rpt_time = latched arrival and rpt_timeout = 0.
REQ-022 In CONFIRM, a valid sample below threshold SHALL clear count and return to WAIT, discarding the latched arrival.
REQ-023 In WAIT/CONFIRM with captured timeout nonzero and timer == timeout, the block SHALL enter REPORT with rpt_time = timeout and rpt_timeout = 1.
REQ-024 When confirmation completes in the same cycle as timeout, confirmation SHALL win.
REQ-025 In REPORT, rpt_valid SHALL be 1, and rpt_time/rpt_timeout SHALL stay stable until rpt_valid && rpt_ready, after which the block SHALL return to IDLE on the next cycle.
REQ-026 Latency SHALL be exactly one cycle from the deciding sample (or timeout cycle) to rpt_valid.

Reset
REQ-027 rst SHALL force IDLE and drive busy = 0, rpt_valid = 0, rpt_time = 0, rpt_timeout = 0, with timer, count and captured values cleared, from any state including mid-measurement.
REQ-028 While rst is asserted, start SHALL be ignored.

Configuration
REQ-029 With OUTLET_FRONT_DETECTOR_PEAK_EN defined, the block SHALL add output rpt_peak (SAMPLE_W bits): the maximum valid sample seen from entering WAIT until REPORT, cleared on start and reset, and held stable with the report.
REQ-030 Without OUTLET_FRONT_DETECTOR_PEAK_EN, neither rpt_peak nor its logic SHALL exist.

Structure
REQ-031 The state enum and default widths SHALL live in shared package mfda_sense_pkg.
REQ-032 Detection SHALL be a single module with no sub-modules; the saturating timer MAY be a small sub-module mfda_sat_counter.

Verification
REQ-033 Default parameters, threshold 0x800, timeout 0: start; samples 0x100 for timer 0..9, then 0x900 at timer 10..13 -> rpt_valid at timer 14, rpt_time = 10, rpt_timeout = 0.
REQ-034 Same setup, samples 0x900 at 10..12, 0x7FF at 13, 0x900 at 20..23 -> rpt_time = 20.
REQ-035 timeout = 50, all samples 0x100 -> rpt_valid one cycle after timer 50, rpt_time = 50, rpt_timeout = 1.
REQ-036 rpt_ready held low for 5 cycles with a second start pulse during REPORT -> outputs stable, start ignored, IDLE after the handshake.
REQ-037 rst asserted in CONFIRM -> next cycle busy = 0, rpt_valid = 0; a fresh start measures from 0.
REQ-038 With PEAK_EN, samples 0x900, 0xA00, 0x950, 0x980 -> rpt_peak = 0xA00.
